instr_encoder: RTL

//  Packs instruction fields into the 32-bit control-unit instruction word: data[31:16], addr1[15:11],

---
 rtl/instr_encoder.sv | 82 ++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Packs control-unit instruction fields into a 32-bit word and buffers it in a
// DEPTH-entry valid/ready FIFO; rejected field sets (read & write) are counted.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_data,
    input  logic [4:0]               in_addr1,
    input  logic                     in_read,
    input  logic                     in_write,
    input  logic                     in_load_imm,
    input  logic [3:0]               in_opcode,
    input  logic [3:0]               in_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_illegal,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      word;
    logic             accept;
    logic             illegal;
    logic             push;
    logic             pop;
    logic             reject;

    assign word      = {in_data, in_addr1, in_read, in_write, in_load_imm, in_opcode, in_flags};
    assign in_ready  = (level != LVL_W'(DEPTH));
    assign out_valid = (level != '0);
    assign accept    = in_valid & in_ready;
    assign illegal   = in_read & in_write;
    assign push      = accept & ~illegal;
    assign reject    = accept & illegal;
    assign pop       = out_valid & out_ready;
    // Head is gated so an emptied FIFO always presents zero, even with stale storage.
    assign out_instr = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            err_illegal <= 1'b0;
            err_cnt     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            err_illegal <= reject;
            if (reject && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule
